// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

  // Control FSM states: normal flow, frozen on a data-memory wait, timed out.
  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } ctrl_state_t;

  // Architectural zero register; writes to it never create a hazard.
  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencing for the 5-stage RV32I core: load-use stalls, EX redirects,
// data-memory wait freeze with timeout, and stall/flush performance counters.
module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  pipe_hold,
  output logic                  mem_wb_bubble,
  output logic                  mem_timeout_err,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              load_use;
  logic              freeze;

  // The load in EX writes a register the ID instruction reads.
  assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_X0)) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // State and wait-cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state and Mealy control outputs; reset forces a flushed, idle pipe.
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    freeze          = 1'b0;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    pipe_hold       = 1'b0;
    mem_wb_bubble   = 1'b0;
    mem_timeout_err = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          freeze = 1'b1;
          if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ERROR;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      ERROR: begin
        freeze          = 1'b1;
        mem_timeout_err = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    // A redirect seen during a freeze stays held in EX and is taken at release.
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      pipe_hold     = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end

    if (reset) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      pipe_hold       = 1'b0;
      mem_wb_bubble   = 1'b1;
      mem_timeout_err = 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (reset),
    .inc  (!reset && !pc_write),
    .clear(1'b0),
    .count(stall_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (reset),
    .inc  (!reset && if_id_flush),
    .clear(1'b0),
    .count(flush_count)
  );

endmodule
